mem_port_arbiter: RTL

Shares the single external memory port between the instruction-fetch requester and the load/store requester, replacing the clock-phase split of fetch and data access. Grants one transaction at a time over a req/ack handshake, tolerates variable memory latency, guarantees fetch progress under data pressure, and terminates stalled transactions with an error response. Sits between the core and the memory bus.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Ports: i_clk/i_nreset, if_* fetch side, d_* data side, mem_* memory bus.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic                i_clk,
    input  logic                i_nreset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_ack,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_err,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_wstrb,
    output logic                o_d_ack,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_d_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t           state;
    logic             gnt_d;
    logic [SW-1:0]    streak;
    logic [CNT_W-1:0] cnt;
    logic             pick_d;
    logic             timed_out;

    // Fetch wins only once data has hogged the port MAX_STREAK times.
    assign pick_d    = i_d_req && !(i_if_req && (streak == STREAK_MAX));
    assign timed_out = TO_EN && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state       <= IDLE;
            gnt_d       <= 1'b0;
            streak      <= '0;
            cnt         <= '0;
            o_if_ack    <= 1'b0;
            o_if_rdata  <= '0;
            o_if_err    <= 1'b0;
            o_d_ack     <= 1'b0;
            o_d_rdata   <= '0;
            o_d_err     <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_if_req || i_d_req) begin
                        gnt_d     <= pick_d;
                        cnt       <= '0;
                        o_mem_req <= 1'b1;
                        state     <= BUSY;
                        if (pick_d) begin
                            o_mem_we    <= i_d_we;
                            o_mem_addr  <= i_d_addr;
                            o_mem_wdata <= i_d_wdata;
                            // Byte enables are meaningless on reads.
                            o_mem_wstrb <= i_d_we ? i_d_wstrb : '0;
                            if (!i_if_req)
                                streak <= '0;
                            else if (streak != STREAK_MAX)
                                streak <= streak + 1'b1;
                        end else begin
                            o_mem_we    <= 1'b0;
                            o_mem_addr  <= i_if_addr;
                            o_mem_wdata <= '0;
                            o_mem_wstrb <= '0;
                            streak      <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        state     <= RESP;
                        if (gnt_d) begin
                            o_d_ack   <= 1'b1;
                            o_d_err   <= 1'b0;
                            o_d_rdata <= o_mem_we ? '0 : i_mem_rdata;
                        end else begin
                            o_if_ack   <= 1'b1;
                            o_if_err   <= 1'b0;
                            o_if_rdata <= i_mem_rdata;
                        end
                    end else if (timed_out) begin
                        o_mem_req <= 1'b0;
                        state     <= RESP;
                        if (gnt_d) begin
                            o_d_ack   <= 1'b1;
                            o_d_err   <= 1'b1;
                            o_d_rdata <= '0;
                        end else begin
                            o_if_ack   <= 1'b1;
                            o_if_err   <= 1'b1;
                            o_if_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    o_if_ack <= 1'b0;
                    o_if_err <= 1'b0;
                    o_d_ack  <= 1'b0;
                    o_d_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
